// File: rtl/div_rem_pkg.sv
// div_rem_pkg: shared types and constants for the iterative unsigned divider.
//   state_e                 - divider FSM states (IDLE, BUSY, DONE)
//   DIV_REM_DEFAULT_WIDTH   - default operand/result width
//   div_rem_cnt_width()     - bit width of the step counter for a given WIDTH
package div_rem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int unsigned DIV_REM_DEFAULT_WIDTH = 32;

  function automatic int unsigned div_rem_cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_rem_if.sv
// div_rem_if: operand/result handshake bundle for div_rem.
//   in_valid/in_ready  - operand pair handshake, n = dividend, d = divisor
//   out_valid/out_ready - result handshake, q = quotient, r = remainder
// Modports: master (producer/consumer side), slave (the divider).
interface div_rem_if
  import div_rem_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_REM_DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (
    output in_valid, n, d, out_ready,
    input  in_ready, out_valid, q, r
  );

  modport slave (
    input  in_valid, n, d, out_ready,
    output in_ready, out_valid, q, r
  );

endinterface

// File: rtl/div_rem_step.sv
// div_rem_step: one combinational restoring-division step.
//   rem      in  WIDTH+1 : partial remainder
//   n_bit    in  1       : next dividend bit (MSB first)
//   d        in  WIDTH   : divisor
//   rem_next out WIDTH+1 : partial remainder after this step
//   q_bit    out 1       : quotient bit produced by this step
module div_rem_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             n_bit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  // The partial remainder is always < d, so its top bit never carries
  // information into the shift; it is kept only for width symmetry.
  logic           unused_rem_msb;

  assign unused_rem_msb = rem[WIDTH];

  always_comb begin
    shifted  = {rem[WIDTH-1:0], n_bit};
    diff     = shifted - {1'b0, d};
    q_bit    = (shifted >= {1'b0, d});
    rem_next = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/div_rem.sv
// div_rem: iterative unsigned divider, one quotient bit per cycle.
//   clk   in : clock, rising edge
//   rst_n in : synchronous reset, active-low
//   bus   slave modport of div_rem_if (n, d in; q, r out; valid/ready both ways)
// Produces q = n / d and r = n % d; d == 0 gives q = all ones, r = n.
// Latency WIDTH+1 cycles from accept to out_valid.
// Optional macro DIV_REM_EARLY_OUT_EN: d == 0 or n < d completes in 1 cycle.
module div_rem
  import div_rem_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_REM_DEFAULT_WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  div_rem_if.slave  bus
);

  localparam int unsigned CW = div_rem_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  // Dividend shifts out of the MSB while quotient bits shift into the LSB.
  logic [WIDTH-1:0] n_shift_q, n_shift_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  div_rem_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .n_bit    (n_shift_q[WIDTH-1]),
    .d        (d_q),
    .rem_next (step_rem),
    .q_bit    (step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    n_shift_d   = n_shift_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    r_d         = r_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          d_d        = bus.d;
          n_shift_d  = bus.n;
          rem_d      = '0;
          cnt_d      = CNT_LOAD;
          state_d    = BUSY;
          in_ready_d = 1'b0;
`ifdef DIV_REM_EARLY_OUT_EN
          if ((bus.d == '0) || (bus.n < bus.d)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            r_d         = bus.n;
            if (bus.d == '0) begin
              q_d = '1;
            end else begin
              q_d = '0;
            end
          end
`endif
        end
      end

      BUSY: begin
        rem_d     = step_rem;
        n_shift_d = {n_shift_q[WIDTH-2:0], step_qbit};
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          q_d         = {n_shift_q[WIDTH-2:0], step_qbit};
          r_d         = step_rem[WIDTH-1:0];
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      n_shift_q   <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      n_shift_q   <= n_shift_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      r_q         <= r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.r         = r_q;

endmodule

// File: tb/tb_div_rem.sv
// tb_div_rem: self-checking bench for div_rem (WIDTH = 32).
// Expected results come from plain integer division; expected latency
// follows the DIV_REM_EARLY_OUT_EN build option.
module tb_div_rem;
  import div_rem_pkg::*;

  localparam int unsigned W = 32;
  localparam int FULL_LAT = W + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  div_rem_if #(.WIDTH(W)) bus ();

  div_rem #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] model_q(input logic [W-1:0] nn, input logic [W-1:0] dd);
    if (dd == 0) return {W{1'b1}};
    return nn / dd;
  endfunction

  function automatic logic [W-1:0] model_r(input logic [W-1:0] nn, input logic [W-1:0] dd);
    if (dd == 0) return nn;
    return nn % dd;
  endfunction

  function automatic int model_lat(input logic [W-1:0] nn, input logic [W-1:0] dd);
`ifdef DIV_REM_EARLY_OUT_EN
    if (dd == 0 || nn < dd) return 1;
`endif
    return FULL_LAT;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and returns at the first cycle with out_valid high.
  // lat is the cycle index (accept = c0) where out_valid was seen; 0 means
  // in_ready never came. rdy_busy counts cycles in_ready was seen while waiting.
  task automatic do_op(input logic [W-1:0] nn, input logic [W-1:0] dd, input bit hold_valid,
                       output int lat, output logic [W-1:0] qo, output logic [W-1:0] ro,
                       output int rdy_busy);
    int waitc;
    waitc = 0;
    lat = 0;
    qo = '0;
    ro = '0;
    rdy_busy = 0;
    while (!bus.in_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    if (!bus.in_ready) return;
    bus.in_valid = 1'b1;
    bus.n = nn;
    bus.d = dd;
    tick();
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_busy++;
      bus.in_valid = hold_valid;
      bus.n = $urandom;
      bus.d = $urandom;
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    qo = bus.q;
    ro = bus.r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.q !== '0 || bus.r !== '0) begin
      failures++;
      $display("FAIL reset_qr: got q=%h r=%h want 0/0", bus.q, bus.r);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int lat, rb;
    logic [W-1:0] qo, ro;
    do_op(32'd100, 32'd7, 1'b0, lat, qo, ro, rb);
    checks++;
    if (lat !== FULL_LAT) begin
      failures++;
      $display("FAIL basic_latency: got %0d want %0d", lat, FULL_LAT);
    end
    checks++;
    if (qo !== 32'd14 || ro !== 32'd2) begin
      failures++;
      $display("FAIL basic_100_7: got q=%0d r=%0d want q=14 r=2", qo, ro);
    end
    checks++;
    if (rb !== 0) begin
      failures++;
      $display("FAIL basic_in_ready_busy: got %0d cycles want 0", rb);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] tn [4];
    logic [W-1:0] td [4];
    bit           th [4];
    int lat, rb;
    logic [W-1:0] qo, ro;
    tn[0] = 32'hFFFF_FFFF; td[0] = 32'd1;          th[0] = 1'b0;
    tn[1] = 32'hFFFF_FFFF; td[1] = 32'h8000_0000;  th[1] = 1'b0;
    tn[2] = 32'd5;         td[2] = 32'd0;          th[2] = 1'b0;
    tn[3] = 32'd3;         td[3] = 32'd10;         th[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(tn[i], td[i], th[i], lat, qo, ro, rb);
      checks++;
      if (qo !== model_q(tn[i], td[i]) || ro !== model_r(tn[i], td[i])) begin
        failures++;
        $display("FAIL edge_result[%0d] %h/%h: got q=%h r=%h want q=%h r=%h",
                 i, tn[i], td[i], qo, ro, model_q(tn[i], td[i]), model_r(tn[i], td[i]));
      end
      checks++;
      if (lat !== model_lat(tn[i], td[i])) begin
        failures++;
        $display("FAIL edge_latency[%0d]: got %0d want %0d", i, lat, model_lat(tn[i], td[i]));
      end
      checks++;
      if (rb !== 0) begin
        failures++;
        $display("FAIL edge_in_ready_busy[%0d]: got %0d want 0", i, rb);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat, rb;
    logic [W-1:0] qo, ro;
    bus.out_ready = 1'b0;
    do_op(32'd1000, 32'd3, 1'b0, lat, qo, ro, rb);
    checks++;
    if (qo !== 32'd333 || ro !== 32'd1 || lat !== FULL_LAT) begin
      failures++;
      $display("FAIL bp_result: got q=%0d r=%0d lat=%0d want q=333 r=1 lat=%0d", qo, ro, lat, FULL_LAT);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.q !== 32'd333 || bus.r !== 32'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b q=%0d r=%0d want 1/0/333/1",
                 i, bus.out_valid, bus.in_ready, bus.q, bus.r);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.q !== 32'd333) begin
      failures++;
      $display("FAIL bp_sixth: got out_valid=%b q=%0d want 1/333", bus.out_valid, bus.q);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.q !== 32'd333 || bus.r !== 32'd1) begin
      failures++;
      $display("FAIL bp_after: got out_valid=%b in_ready=%b q=%0d r=%0d want 0/1/333/1",
               bus.out_valid, bus.in_ready, bus.q, bus.r);
    end
  endtask

  task automatic test_reset_abort();
    int lat, rb, seen;
    logic [W-1:0] qo, ro;
    bus.in_valid = 1'b1;
    bus.n = 32'd50;
    bus.d = 32'd5;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.q !== '0) begin
      failures++;
      $display("FAIL abort_reset: got out_valid=%b in_ready=%b q=%h want 0/0/0", bus.out_valid, bus.in_ready, bus.q);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_in_ready: got %b want 1", bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_result: got %0d out_valid cycles want 0", seen);
    end
    do_op(32'd9, 32'd4, 1'b0, lat, qo, ro, rb);
    checks++;
    if (qo !== 32'd2 || ro !== 32'd1 || lat !== FULL_LAT) begin
      failures++;
      $display("FAIL abort_next_op: got q=%0d r=%0d lat=%0d want 2/1/%0d", qo, ro, lat, FULL_LAT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, rb, stall;
    logic [W-1:0] nn, dd, qo, ro;
    for (int k = 0; k < 40; k++) begin
      nn = $urandom;
      case ($urandom_range(0, 4))
        0: dd = '0;
        1: begin dd = $urandom; nn = $urandom_range(0, 1000); end
        2: dd = $urandom_range(1, 255);
        3: dd = $urandom;
        default: dd = 32'h8000_0000 | $urandom;
      endcase
      stall = $urandom_range(0, 3);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", k, bus.in_ready);
      end
      bus.out_ready = (stall == 0);
      do_op(nn, dd, $urandom_range(0, 1) == 1, lat, qo, ro, rb);
      checks++;
      if (qo !== model_q(nn, dd) || ro !== model_r(nn, dd) || lat !== model_lat(nn, dd)) begin
        failures++;
        $display("FAIL b2b_result[%0d] %h/%h: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                 k, nn, dd, qo, ro, lat, model_q(nn, dd), model_r(nn, dd), model_lat(nn, dd));
      end
      for (int s = 0; s < stall; s++) begin
        tick();
        if (s == stall - 1) bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.q !== qo || bus.r !== ro) begin
          failures++;
          $display("FAIL b2b_stall[%0d]: got out_valid=%b q=%h r=%h want 1/%h/%h", k, bus.out_valid, bus.q, bus.r, qo, ro);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.n = '0;
    bus.d = '0;
    test_reset();
    test_basic();
    test_edges();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
